note_sequencer: RTL and testbench

//  Steps through a small writable melody pattern and drives the maxval divider input and

---
 rtl/sound_pkg.sv | 56 +++++
 rtl/note_lut.sv | 20 ++
 rtl/note_sequencer.sv | 136 +++++++++++++
 tb/tb_note_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared note codes, pattern entry layout and the octave-0 divider table (12 MHz clk_i).
// Build option: SEQ_LOOP_EN enables looping playback in note_sequencer.
package sound_pkg;

  typedef enum logic [3:0] {
    NOTE_REST = 4'd0,
    NOTE_C    = 4'd1,
    NOTE_CS   = 4'd2,
    NOTE_D    = 4'd3,
    NOTE_DS   = 4'd4,
    NOTE_E    = 4'd5,
    NOTE_F    = 4'd6,
    NOTE_FS   = 4'd7,
    NOTE_G    = 4'd8,
    NOTE_GS   = 4'd9,
    NOTE_A    = 4'd10,
    NOTE_AS   = 4'd11,
    NOTE_B    = 4'd12
  } note_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } seq_state_t;

  localparam int ENTRY_W  = 10;
  localparam int NOTE_LSB = 6;
  localparam int NOTE_W   = 4;
  localparam int OCT_LSB  = 4;
  localparam int OCT_W    = 2;
  localparam int DUR_LSB  = 0;
  localparam int DUR_W    = 4;

  // Half-period minus one of the octave-4 pitch: 6e6/f - 1.
  function automatic logic [15:0] base_div(input logic [3:0] note);
    logic [15:0] d;
    case (note)
      4'd1:    d = 16'd22932;
      4'd2:    d = 16'd21645;
      4'd3:    d = 16'd20430;
      4'd4:    d = 16'd19284;
      4'd5:    d = 16'd18201;
      4'd6:    d = 16'd17180;
      4'd7:    d = 16'd16215;
      4'd8:    d = 16'd15305;
      4'd9:    d = 16'd14446;
      4'd10:   d = 16'd13635;
      4'd11:   d = 16'd12870;
      4'd12:   d = 16'd12148;
      default: d = 16'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/note_lut.sv
// Combinational {note, oct} -> {valid, maxval}; each octave halves the divided period.
module note_lut #(
  parameter int N = 16
) (
  input  logic [3:0]   note,
  input  logic [1:0]   oct,
  output logic         valid,
  output logic [N-1:0] maxval
);
  import sound_pkg::*;

  logic [16:0] period;

  always_comb begin
    valid  = (note >= 4'd1) && (note <= 4'd12);
    period = ({1'b0, base_div(note)} + 17'd1) >> oct;
    maxval = N'(period - 17'd1);
  end

endmodule

// File: rtl/note_sequencer.sv
// Plays a writable pattern of {note, oct, dur} entries, driving clkgen maxval and tone gate.
// Build option: SEQ_LOOP_EN adds loop_i to restart at entry 0 instead of finishing.
module note_sequencer #(
  parameter  int N      = 16,
  parameter  int DEPTH  = 16,
  parameter  int TICK_W = 24,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset,
`ifdef SEQ_LOOP_EN
  input  logic              loop_i,
`endif
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [9:0]        wr_data,
  input  logic [AW-1:0]     length,
  input  logic [TICK_W-1:0] tick_len,
  input  logic              start,
  input  logic              stop,
  output logic [N-1:0]      maxval,
  output logic              tone_en,
  output logic [AW-1:0]     step_idx,
  output logic              busy,
  output logic              done
);
  import sound_pkg::*;

  seq_state_t state, state_nxt;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] entry;
  logic [TICK_W-1:0]  tick_ctr;
  logic [DUR_W-1:0]   dur_ctr;
  logic [AW-1:0]      len_eff;
  logic               lut_valid;
  logic [N-1:0]       lut_maxval;
  logic               tick_wrap;
  logic               last;
  logic               step_end;
  logic               loop_now;

`ifdef SEQ_LOOP_EN
  assign loop_now = loop_i;
`else
  assign loop_now = 1'b0;
`endif

  // Pattern RAM is deliberately not reset so a melody survives a reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Asynchronous read: a same-cycle write to this address lands after the LOAD sample.
  assign entry = mem[step_idx];

  note_lut #(.N(N)) u_lut (
    .note   (entry[NOTE_LSB +: NOTE_W]),
    .oct    (entry[OCT_LSB +: OCT_W]),
    .valid  (lut_valid),
    .maxval (lut_maxval)
  );

  assign len_eff   = ({1'b0, length} > (AW+1)'(DEPTH-1)) ? AW'(DEPTH-1) : length;
  assign tick_wrap = (tick_ctr >= tick_len);
  assign last      = (step_idx == len_eff);
  assign step_end  = (state == ST_PLAY) && tick_wrap && (dur_ctr == '0);

  always_ff @(posedge clk_i) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_nxt = ST_LOAD;
        ST_LOAD: state_nxt = ST_PLAY;
        ST_PLAY: if (step_end) state_nxt = (last && !loop_now) ? ST_IDLE : ST_LOAD;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      maxval   <= '0;
      tone_en  <= 1'b0;
      step_idx <= '0;
      done     <= 1'b0;
      tick_ctr <= '0;
      dur_ctr  <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        tone_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (start) step_idx <= '0;
          ST_LOAD: begin
            tick_ctr <= '0;
            dur_ctr  <= entry[DUR_LSB +: DUR_W];
            tone_en  <= lut_valid;
            if (lut_valid) maxval <= lut_maxval;
          end
          ST_PLAY: begin
            if (tick_wrap) begin
              tick_ctr <= '0;
              if (dur_ctr != '0) begin
                dur_ctr <= dur_ctr - DUR_W'(1);
              end else if (!last) begin
                step_idx <= step_idx + AW'(1);
              end else if (loop_now) begin
                step_idx <= '0;
              end else begin
                done    <= 1'b1;
                tone_en <= 1'b0;
              end
            end else begin
              tick_ctr <= tick_ctr + TICK_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Randomized and directed playback checked cycle by cycle against an expanded-schedule model.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [9:0]  wr_data;
  logic [3:0]  length;
  logic [23:0] tick_len;
  logic        start;
  logic        stop;
  logic [15:0] maxval;
  logic        tone_en;
  logic [3:0]  step_idx;
  logic        busy;
  logic        done;
`ifdef SEQ_LOOP_EN
  logic        loop_r;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0]  mem_m [16];
  logic [15:0] m_max = 16'd0;
  logic [3:0]  m_idx = 4'd0;
  logic [22:0] exp_q [$];
  int          pass_len;

  always #5 clk = ~clk;

  note_sequencer #(.N(16), .DEPTH(16), .TICK_W(24)) dut (
    .clk_i    (clk),
    .reset    (reset),
`ifdef SEQ_LOOP_EN
    .loop_i   (loop_r),
`endif
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .length   (length),
    .tick_len (tick_len),
    .start    (start),
    .stop     (stop),
    .maxval   (maxval),
    .tone_en  (tone_en),
    .step_idx (step_idx),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (idx,maxval,tone,busy,done)", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [22:0] pk(input logic [3:0] i, input logic [15:0] m,
                                     input logic t, input logic b, input logic d);
    return {i, m, t, b, d};
  endfunction

  function automatic logic [31:0] obs();
    return {9'd0, step_idx, maxval, tone_en, busy, done};
  endfunction

  // Equal-tempered octave-4 pitches; divider = 12e6/(2f) - 1, halved per octave.
  function automatic int ref_div(input int note, input int oct);
    int base [13] = '{0, 22932, 21645, 20430, 19284, 18201, 17180,
                      16215, 15305, 14446, 13635, 12870, 12148};
    return ((base[note] + 1) >> oct) - 1;
  endfunction

  task automatic wr(input int addr, input logic [9:0] data);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_data = data;
    step();
    wr_en = 1'b0;
    mem_m[addr] = data;
  endtask

  // Each entry: one fetch cycle showing the old outputs, then (dur+1)*(tick+1) sounding cycles.
  task automatic build_exp(input int len, input int tl, input int passes);
    logic [15:0] mx;
    logic        tn;
    int          note, oct, dur;
    exp_q.delete();
    mx = m_max; tn = 1'b0; pass_len = 0;
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k <= len; k++) begin
        exp_q.push_back(pk(4'(k), mx, tn, 1'b1, 1'b0));
        note = int'(mem_m[k][9:6]); oct = int'(mem_m[k][5:4]); dur = int'(mem_m[k][3:0]);
        if (note >= 1 && note <= 12) begin
          mx = 16'(ref_div(note, oct)); tn = 1'b1;
        end else begin
          tn = 1'b0;
        end
        for (int c = 0; c < (dur + 1) * (tl + 1); c++) exp_q.push_back(pk(4'(k), mx, tn, 1'b1, 1'b0));
        if (p == 0) pass_len += 1 + (dur + 1) * (tl + 1);
      end
    end
    exp_q.push_back(pk(4'(len), mx, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(pk(4'(len), mx, 1'b0, 1'b0, 1'b0));
  endtask

  // stop_at/restart_at/reset_at: expected-cycle index at which to pulse; -1 none, -2 random.
  task automatic run(input string tag, input int len, input int tl, input int passes,
                     input int stop_at, input int restart_at, input int reset_at);
    int sa, ra, xa, lc;
    logic [22:0] e;
    length = 4'(len); tick_len = 24'(tl);
    build_exp(len, tl, passes);
    sa = (stop_at == -2) ? int'($urandom_range(0, exp_q.size() - 3)) : stop_at;
    ra = (restart_at == -2) ? int'($urandom_range(0, exp_q.size() - 3)) : restart_at;
    xa = reset_at;
    lc = (passes - 1) * pass_len;
`ifdef SEQ_LOOP_EN
    loop_r = (passes > 1);
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      check(tag, obs(), {9'd0, e});
      m_max = e[18:3];
      m_idx = e[22:19];
      if (i == sa) begin
        stop = 1'b1;
        step();
        stop = 1'b0;
        check({tag, "_stop"}, obs(), {9'd0, pk(m_idx, m_max, 1'b0, 1'b0, 1'b0)});
        return;
      end
      if (i == xa) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_max = 16'd0; m_idx = 4'd0;
        check({tag, "_rst"}, obs(), 32'd0);
        return;
      end
      if (i == ra) start = 1'b1;
`ifdef SEQ_LOOP_EN
      if (i == lc) loop_r = 1'b0;
`endif
      step();
      start = 1'b0;
    end
  endtask

  initial begin
    int len, tl;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; length = '0;
    tick_len = '0; start = 1'b0; stop = 1'b0;
`ifdef SEQ_LOOP_EN
    loop_r = 1'b0;
`endif
    for (int k = 0; k < 16; k++) mem_m[k] = 10'd0;
    step();
    check("reset", obs(), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) wr(k, 10'd0);
    check("idle", obs(), 32'd0);

    wr(0, {4'd10, 2'd0, 4'd1});
    run("single_a", 0, 3, 1, -1, -1, -1);

    wr(0, {4'd10, 2'd1, 4'd0});
    wr(1, {4'd0, 2'd0, 4'd0});
    run("a_rest", 1, 3, 1, -1, -1, -1);

    wr(0, {4'd1, 2'd0, 4'd1});
    wr(1, {4'd12, 2'd2, 4'd0});
    wr(2, {4'd14, 2'd3, 4'd1});
    run("stop_mid", 2, 2, 1, 6, -1, -1);
    run("replay", 2, 2, 1, -1, -1, -1);
    run("start_busy", 2, 2, 1, -1, 4, -1);

    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("start_stop", obs(), {9'd0, pk(m_idx, m_max, 1'b0, 1'b0, 1'b0)});
    step();
    check("start_stop2", obs(), {9'd0, pk(m_idx, m_max, 1'b0, 1'b0, 1'b0)});

    run("rst_mid", 2, 2, 1, -1, -1, 8);
    run("after_rst", 2, 2, 1, -1, -1, -1);

`ifdef SEQ_LOOP_EN
    run("loop", 1, 1, 3, -1, -1, -1);
`endif

    for (int it = 0; it < 12; it++) begin
      len = int'($urandom_range(0, 4));
      tl  = int'($urandom_range(0, 3));
      for (int k = 0; k <= len; k++)
        wr(k, {4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3))});
      wr(len + 1, {4'($urandom_range(1, 12)), 2'd0, 4'd0});
      case (it % 3)
        0: run("rand", len, tl, 1, -1, -1, -1);
        1: run("rand_stop", len, tl, 1, -2, -1, -1);
        default: run("rand_busy", len, tl, 1, -1, -2, -1);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
